// File: rtl/fifo_reader_if.sv
// fifo_reader_if: output word stream from the FIFO reader to a downstream PE.
//   out_data  : signed data word, valid while out_valid is high
//   out_valid : word held and offered downstream
//   out_ready : downstream accepts the word when out_valid is also high
//   out_last  : held word is the final word of the burst (FIFO index 0)
// master = fifo_reader (producer), slave = downstream consumer.
interface fifo_reader_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic signed [DATA_WIDTH-1:0] out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: read-side sequencer for the register-file FIFO.
// On start, walks reg_select from the oldest entry (n-1) down to the newest (0),
// samples the combinational FIFO value_out on value_in, and streams the words
// downstream one per cycle over a valid/ready handshake.
// Ports:
//   clk, rstb      : clock (rising edge), asynchronous active-low reset
//   start, count   : begin a burst of min(count, 2**ADDR_WIDTH) words (IDLE only)
//   loop           : (FIFO_READER_LOOP_EN only) restart the burst at its last word
//   reg_select     : FIFO entry index being read
//   value_in       : FIFO value_out for reg_select
//   out_if         : output word stream (out_data/out_valid/out_ready/out_last)
//   busy, done     : burst in progress / single-cycle completion pulse
// Optional feature macro: FIFO_READER_LOOP_EN (adds the loop input).
module fifo_reader #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rstb,
   input  logic                         start,
   input  logic [ADDR_WIDTH:0]          count,
`ifdef FIFO_READER_LOOP_EN
   input  logic                         loop,
`endif
   output logic [ADDR_WIDTH-1:0]        reg_select,
   input  logic signed [DATA_WIDTH-1:0] value_in,
   fifo_reader_if.master                out_if,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned AW    = ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;
   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         sel_q, sel_d;
   logic signed [DW-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef FIFO_READER_LOOP_EN
   logic [AW-1:0]         first_q, first_d;
`endif

   logic [CW-1:0]         n_c;
   logic                  accept_c;
   logic                  cap_last_c;
   logic [AW-1:0]         cap_sel_c;

   // Clamp the requested count to the FIFO depth.
   assign n_c      = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
   assign accept_c = valid_q & out_if.out_ready;

   // Result of capturing the word at sel_q: index 0 is the last word. Once the
   // last word is captured the select is free, so in loop builds it is parked on
   // the first index to let a looped restart capture with no bubble.
   always_comb begin
      cap_last_c = (sel_q == '0);
      if (sel_q != '0) begin
         cap_sel_c = sel_q - AW'(1);
      end else begin
`ifdef FIFO_READER_LOOP_EN
         cap_sel_c = first_q;
`else
         cap_sel_c = '0;
`endif
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FIFO_READER_LOOP_EN
         first_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef FIFO_READER_LOOP_EN
         first_q <= first_d;
`endif
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef FIFO_READER_LOOP_EN
      first_d = first_q;
`endif

      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (start) begin
               if (n_c == '0) begin
                  done_d = 1'b1;
               end else begin
                  sel_d   = AW'(n_c - CW'(1));
                  busy_d  = 1'b1;
                  state_d = FETCH;
`ifdef FIFO_READER_LOOP_EN
                  first_d = AW'(n_c - CW'(1));
`endif
               end
            end
         end

         FETCH: begin
            data_d  = value_in;
            valid_d = 1'b1;
            last_d  = cap_last_c;
            sel_d   = cap_sel_c;
            state_d = STREAM;
         end

         STREAM: begin
            if (accept_c) begin
               if (!last_q) begin
                  data_d = value_in;
                  last_d = cap_last_c;
                  sel_d  = cap_sel_c;
               end
`ifdef FIFO_READER_LOOP_EN
               else if (loop) begin
                  data_d = value_in;
                  last_d = cap_last_c;
                  sel_d  = cap_sel_c;
               end
`endif
               else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  sel_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign reg_select       = sel_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_last  = last_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: self-checking bench for fifo_reader. A FIFO model holds
// 10..17 (10 oldest at index 7); expected words are queued when a burst starts
// and popped as the DUT hands them off. A vector table drives the bursts, and
// hand-written sequences cover latency, stalls, mid-burst reset and looping.
module tb_fifo_reader;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;

   typedef struct {
      logic signed [DW-1:0] data;
      logic                 last;
   } exp_t;

   typedef struct {
      int count;       // requested count
      int mode;        // out_ready: 0 always, 1 pattern 1,0,0, 2 random
      bit mid_start;   // pulse start mid-burst
      int exp_words;   // words expected downstream
      int exp_cycles;  // cycles from start edge to done (-1: not checked)
   } vec_t;

   logic                 clk;
   logic                 rstb;
   logic                 start;
   logic [AW:0]          count;
   logic [AW-1:0]        reg_select;
   logic signed [DW-1:0] value_in;
   logic                 busy;
   logic                 done;
`ifdef FIFO_READER_LOOP_EN
   logic                 loop;
`endif

   fifo_reader_if #(.DATA_WIDTH(DW)) oif ();

   fifo_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .start      (start),
      .count      (count),
`ifdef FIFO_READER_LOOP_EN
      .loop       (loop),
`endif
      .reg_select (reg_select),
      .value_in   (value_in),
      .out_if     (oif),
      .busy       (busy),
      .done       (done)
   );

   logic signed [DW-1:0] fifo_mem [8];
   assign value_in = fifo_mem[reg_select];

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   word_cnt = 0;
   int   done_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input int n);
      for (int i = n - 1; i >= 0; i--) begin
         exp_t e;
         e.data = fifo_mem[i];
         e.last = (i == 0);
         sb.push_back(e);
      end
   endtask

   // Scoreboard monitor: sample at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rstb) begin
         if (done) done_cnt++;
         if (done && oif.out_valid) begin
            checks++;
            failures++;
            $display("FAIL done_with_valid: got done=1 out_valid=1 required not both");
         end
         if (oif.out_valid && oif.out_ready) begin
            word_cnt++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_extra_word: got data %0d with nothing expected", oif.out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (oif.out_data !== e.data || oif.out_last !== e.last) begin
                  failures++;
                  $display("FAIL sb_word: got data %0d last %0b expected data %0d last %0b",
                           oif.out_data, oif.out_last, e.data, e.last);
               end
            end
         end
      end
   end

   // Run one burst from the vector table; waits are bounded.
   task automatic run_burst(input vec_t v, input int idx);
      int  n;
      int  cyc;
      bit  busy_seen;
      n = (v.count > 8) ? 8 : v.count;
      word_cnt  = 0;
      done_cnt  = 0;
      busy_seen = 0;
      push_expected(n);
      start = 1'b1;
      count = (AW+1)'(v.count);
      tick();
      start = 1'b0;
      count = (AW+1)'($urandom_range(0, 15));
      cyc = 0;
      while (!done && cyc < 200) begin
         if (busy) busy_seen = 1;
         case (v.mode)
            0:       oif.out_ready = 1'b1;
            1:       oif.out_ready = (cyc % 3 == 0);
            default: oif.out_ready = 1'($urandom_range(0, 1));
         endcase
         if (v.mid_start && cyc == 2) begin
            start = 1'b1;
            count = (AW+1)'(2);
         end else begin
            start = 1'b0;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      oif.out_ready = 1'b0;
      if (cyc >= 200) begin
         checks++;
         failures++;
         $display("FAIL vec%0d_timeout: got no done after %0d cycles", idx, cyc);
      end
      if (v.exp_cycles >= 0) chk($sformatf("vec%0d_done_cycle", idx), cyc, v.exp_cycles);
      if (v.count == 0) chk($sformatf("vec%0d_busy_never", idx), 32'(busy_seen), 0);
      tick();
      chk($sformatf("vec%0d_words", idx), word_cnt, v.exp_words);
      chk($sformatf("vec%0d_done_pulses", idx), done_cnt, 1);
      chk($sformatf("vec%0d_done_single", idx), 32'(done), 0);
      chk($sformatf("vec%0d_idle_busy", idx), 32'(busy), 0);
      chk($sformatf("vec%0d_idle_sel", idx), 32'(reg_select), 0);
      chk($sformatf("vec%0d_sb_empty", idx), sb.size(), 0);
      sb.delete();
   endtask

   vec_t vecs[7];

   initial begin
      int cyc;
      for (int i = 0; i < 8; i++) fifo_mem[i] = DW'(17 - i);
      vecs[0] = '{count: 8,  mode: 0, mid_start: 0, exp_words: 8, exp_cycles: 9};
      vecs[1] = '{count: 3,  mode: 1, mid_start: 0, exp_words: 3, exp_cycles: -1};
      vecs[2] = '{count: 0,  mode: 0, mid_start: 0, exp_words: 0, exp_cycles: 0};
      vecs[3] = '{count: 12, mode: 0, mid_start: 0, exp_words: 8, exp_cycles: 9};
      vecs[4] = '{count: 1,  mode: 0, mid_start: 0, exp_words: 1, exp_cycles: 2};
      vecs[5] = '{count: 5,  mode: 2, mid_start: 1, exp_words: 5, exp_cycles: -1};
      vecs[6] = '{count: 15, mode: 1, mid_start: 0, exp_words: 8, exp_cycles: -1};

      rstb          = 1'b0;
      start         = 1'b0;
      count         = '0;
      oif.out_ready = 1'b0;
`ifdef FIFO_READER_LOOP_EN
      loop          = 1'b0;
`endif
      tick();
      tick();
      chk("rst_valid", 32'(oif.out_valid), 0);
      chk("rst_data", 32'(oif.out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rstb = 1'b1;
      tick();
      chk("idle_sel", 32'(reg_select), 0);

      // First-word latency and reg_select stepping with a stalled consumer.
      word_cnt = 0;
      done_cnt = 0;
      push_expected(3);
      start = 1'b1;
      count = 4'd3;
      tick();
      start = 1'b0;
      chk("lat_busy_e0", 32'(busy), 1);
      chk("lat_sel_e0", 32'(reg_select), 2);
      chk("lat_valid_e0", 32'(oif.out_valid), 0);
      tick();
      chk("lat_valid_e1", 32'(oif.out_valid), 1);
      chk("lat_data_e1", 32'(oif.out_data), 15);
      chk("lat_sel_e1", 32'(reg_select), 1);
      tick();
      tick();
      chk("stall_data", 32'(oif.out_data), 15);
      chk("stall_sel", 32'(reg_select), 1);
      chk("stall_last", 32'(oif.out_last), 0);
      oif.out_ready = 1'b1;
      tick();
      chk("step_data", 32'(oif.out_data), 16);
      chk("step_sel", 32'(reg_select), 0);
      tick();
      chk("last_data", 32'(oif.out_data), 17);
      chk("last_flag", 32'(oif.out_last), 1);
      tick();
      oif.out_ready = 1'b0;
      chk("end_done", 32'(done), 1);
      chk("end_valid", 32'(oif.out_valid), 0);
      chk("end_busy", 32'(busy), 0);
      tick();
      chk("end_words", word_cnt, 3);
      chk("end_done_cnt", done_cnt, 1);

      for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

      // Reset while the 4th word (13) of an 8-word burst is held.
      word_cnt = 0;
      done_cnt = 0;
      push_expected(8);
      start = 1'b1;
      count = 4'd8;
      tick();
      start = 1'b0;
      oif.out_ready = 1'b1;
      cyc = 0;
      while (!(oif.out_valid && oif.out_data == 13) && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("rstmid_reached", 32'(oif.out_data), 13);
      rstb = 1'b0;
      #1;
      sb.delete();
      chk("rstmid_valid", 32'(oif.out_valid), 0);
      chk("rstmid_data", 32'(oif.out_data), 0);
      chk("rstmid_last", 32'(oif.out_last), 0);
      chk("rstmid_sel", 32'(reg_select), 0);
      chk("rstmid_busy", 32'(busy), 0);
      oif.out_ready = 1'b0;
      tick();
      tick();
      rstb = 1'b1;
      tick();
      chk("rstmid_no_done", done_cnt, 0);
      chk("rstmid_words", word_cnt, 3);
      run_burst(vecs[0], 7);

`ifdef FIFO_READER_LOOP_EN
      // Looped burst: 16,17,16,17 with no bubble, done only after the second pass.
      word_cnt = 0;
      done_cnt = 0;
      push_expected(2);
      push_expected(2);
      loop  = 1'b1;
      start = 1'b1;
      count = 4'd2;
      tick();
      start = 1'b0;
      oif.out_ready = 1'b1;
      tick();
      tick();
      tick();
      loop = 1'b0;
      chk("loop_valid", 32'(oif.out_valid), 1);
      chk("loop_data", 32'(oif.out_data), 16);
      chk("loop_busy", 32'(busy), 1);
      chk("loop_no_done", done_cnt, 0);
      tick();
      tick();
      chk("loop_done", 32'(done), 1);
      oif.out_ready = 1'b0;
      tick();
      chk("loop_words", word_cnt, 4);
      chk("loop_done_cnt", done_cnt, 1);
      chk("loop_sb_empty", sb.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
